// File: rtl/mem_stage_ws.sv
// mem_stage_ws: pipeline MEM stage with a banked, byte-addressed little-endian data memory and wait states.
// Defining MEM_STAGE_PERF_EN adds the stall_cycles output (cycles with in_valid high while not ready).
module mem_stage_ws #(
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] imm,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] store_data,
  input  logic              data_in_src,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic              size,
  input  logic              sign_ext,
  input  logic [1:0]        wb_sel,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic              err
`ifdef MEM_STAGE_PERF_EN
  ,
  output logic [15:0]       stall_cycles
`endif
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int AW    = $clog2(DEPTH);
  localparam int RW    = AW - OFF_W;
  localparam int ROWS  = DEPTH / BYTES;
  localparam logic [3:0] WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        accept;
  logic        exec;

  logic [DATA_W-1:0] alu_reg, imm_reg, pc_reg, sdata_reg;
  logic              rd_reg, wr_reg, size_reg, sext_reg;
  logic [1:0]        wbsel_reg;

  logic [DATA_W-1:0] cur_alu, cur_imm, cur_pc, cur_wdata;
  logic              cur_rd, cur_wr, cur_size, cur_sext;
  logic [1:0]        cur_wbsel;

  logic [AW-1:0]     addr;
  logic [RW-1:0]     row;
  logic [OFF_W-1:0]  off;
  logic              illegal;
  logic              we;
  logic [7:0]        rd_lane [BYTES];
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] wb_next;

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    in_ready   = 1'b0;
    exec       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) begin
          if ((mem_rd || mem_wr) && (WAIT_STATES != 0)) begin
            state_next = BUSY;
            cnt_next   = WS_LOAD;
          end else begin
            exec = 1'b1;
          end
        end
      end
      BUSY: begin
        if (cnt_reg == 4'd0) begin
          exec       = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operands are held here for multi-cycle accesses; the store source is resolved at accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      alu_reg   <= alu_result;
      imm_reg   <= imm;
      pc_reg    <= pc;
      sdata_reg <= data_in_src ? store_data : imm;
      rd_reg    <= mem_rd;
      wr_reg    <= mem_wr;
      size_reg  <= size;
      sext_reg  <= sign_ext;
      wbsel_reg <= wb_sel;
    end
  end

  // Single-cycle ops execute straight from the inputs on the accept edge.
  always_comb begin
    if (state_reg == IDLE) begin
      cur_alu   = alu_result;
      cur_imm   = imm;
      cur_pc    = pc;
      cur_wdata = data_in_src ? store_data : imm;
      cur_rd    = mem_rd;
      cur_wr    = mem_wr;
      cur_size  = size;
      cur_sext  = sign_ext;
      cur_wbsel = wb_sel;
    end else begin
      cur_alu   = alu_reg;
      cur_imm   = imm_reg;
      cur_pc    = pc_reg;
      cur_wdata = sdata_reg;
      cur_rd    = rd_reg;
      cur_wr    = wr_reg;
      cur_size  = size_reg;
      cur_sext  = sext_reg;
      cur_wbsel = wbsel_reg;
    end
  end

  assign addr    = cur_alu[AW-1:0];
  assign row     = addr[AW-1:OFF_W];
  assign off     = addr[OFF_W-1:0];
  assign illegal = (cur_rd && cur_wr) || ((cur_rd || cur_wr) && cur_size && (off != '0));
  assign we      = exec && rst_n && cur_wr && !illegal;

  // One byte-wide bank per lane; aligned words hit the same row in every bank.
  generate
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_bank
      logic [7:0] bank [ROWS];

      always_ff @(posedge clk) begin
        if (we && (cur_size || (off == OFF_W'(gi)))) begin
          bank[row] <= cur_size ? cur_wdata[gi*8 +: 8] : cur_wdata[7:0];
        end
      end

      assign rd_lane[gi]         = bank[row];
      assign rd_word[gi*8 +: 8] = rd_lane[gi];
    end
  endgenerate

  always_comb begin
    load_val = '0;
    if (cur_rd && !illegal) begin
      if (cur_size) begin
        load_val = rd_word;
      end else begin
        load_val = {{(DATA_W-8){cur_sext & rd_lane[off][7]}}, rd_lane[off]};
      end
    end
  end

  always_comb begin
    case (cur_wbsel)
      2'd0:    wb_next = cur_pc;
      2'd1:    wb_next = cur_alu;
      2'd2:    wb_next = load_val;
      default: wb_next = cur_imm;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_data  <= '0;
      err      <= 1'b0;
    end else begin
      wb_valid <= exec;
      err      <= exec && illegal;
      if (exec) begin
        wb_data <= wb_next;
      end
    end
  end

`ifdef MEM_STAGE_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= 16'd0;
    end else if (in_valid && !in_ready && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_stage_ws.sv
// tb_mem_stage_ws: directed vector table on a default instance, plus hand sequences for
// back-to-back ops, reset abort with WAIT_STATES = 3, and stall counting with WAIT_STATES = 2.
module tb_mem_stage_ws;

  logic        clk = 1'b0;
  logic        rst_n_a, rst_n_b, rst_n_c;
  logic        in_valid_a, in_valid_b, in_valid_c;
  logic        in_ready_a, in_ready_b, in_ready_c;
  logic [15:0] alu_result, imm, pc, store_data;
  logic        data_in_src, mem_rd, mem_wr, size, sign_ext;
  logic [1:0]  wb_sel;
  logic        wb_valid_a, wb_valid_b, wb_valid_c;
  logic [15:0] wb_data_a, wb_data_b, wb_data_c;
  logic        err_a, err_b, err_c;
`ifdef MEM_STAGE_PERF_EN
  logic [15:0] stall_a, stall_b, stall_c;
`endif

  always #5 clk = ~clk;

  mem_stage_ws dut_a (
    .clk(clk), .rst_n(rst_n_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .alu_result(alu_result), .imm(imm), .pc(pc), .store_data(store_data),
    .data_in_src(data_in_src), .mem_rd(mem_rd), .mem_wr(mem_wr), .size(size),
    .sign_ext(sign_ext), .wb_sel(wb_sel), .wb_valid(wb_valid_a), .wb_data(wb_data_a),
    .err(err_a)
`ifdef MEM_STAGE_PERF_EN
    , .stall_cycles(stall_a)
`endif
  );

  mem_stage_ws #(.WAIT_STATES(3)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .alu_result(alu_result), .imm(imm), .pc(pc), .store_data(store_data),
    .data_in_src(data_in_src), .mem_rd(mem_rd), .mem_wr(mem_wr), .size(size),
    .sign_ext(sign_ext), .wb_sel(wb_sel), .wb_valid(wb_valid_b), .wb_data(wb_data_b),
    .err(err_b)
`ifdef MEM_STAGE_PERF_EN
    , .stall_cycles(stall_b)
`endif
  );

  mem_stage_ws #(.WAIT_STATES(2)) dut_c (
    .clk(clk), .rst_n(rst_n_c), .in_valid(in_valid_c), .in_ready(in_ready_c),
    .alu_result(alu_result), .imm(imm), .pc(pc), .store_data(store_data),
    .data_in_src(data_in_src), .mem_rd(mem_rd), .mem_wr(mem_wr), .size(size),
    .sign_ext(sign_ext), .wb_sel(wb_sel), .wb_valid(wb_valid_c), .wb_data(wb_data_c),
    .err(err_c)
`ifdef MEM_STAGE_PERF_EN
    , .stall_cycles(stall_c)
`endif
  );

  typedef struct {
    string       name;
    logic [15:0] alu, imm, pc, sdata;
    logic        src, rd, wr, sz, sx;
    logic [1:0]  ws;
    logic [15:0] exp_data;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  int tests = 0;
  int fails = 0;
  int sel   = 0;

  logic        cur_wbv, cur_rdy, cur_err;
  logic [15:0] cur_data;

  always_comb begin
    cur_wbv  = wb_valid_a;
    cur_rdy  = in_ready_a;
    cur_err  = err_a;
    cur_data = wb_data_a;
    if (sel == 1) begin
      cur_wbv  = wb_valid_b;
      cur_rdy  = in_ready_b;
      cur_err  = err_b;
      cur_data = wb_data_b;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic [15:0] alu, input logic [15:0] im,
                              input logic [15:0] p, input logic [15:0] sd, input logic src,
                              input logic rd, input logic wr, input logic sz, input logic sx,
                              input logic [1:0] ws, input logic [15:0] ed, input logic ee,
                              input int el);
    vec_t v;
    v.name = n; v.alu = alu; v.imm = im; v.pc = p; v.sdata = sd; v.src = src;
    v.rd = rd; v.wr = wr; v.sz = sz; v.sx = sx; v.ws = ws;
    v.exp_data = ed; v.exp_err = ee; v.exp_lat = el;
    return v;
  endfunction

  task automatic set_valid(input logic v);
    if (sel == 1) in_valid_b = v;
    else in_valid_a = v;
  endtask

  // Issues one op to the selected instance (assumed idle) and checks its writeback.
  task automatic run_op(input vec_t v);
    int lat;
    alu_result = v.alu; imm = v.imm; pc = v.pc; store_data = v.sdata;
    data_in_src = v.src; mem_rd = v.rd; mem_wr = v.wr; size = v.sz; sign_ext = v.sx;
    wb_sel = v.ws;
    set_valid(1'b1);
    @(posedge clk); #1;
    set_valid(1'b0);
    chk({v.name, "/ready"}, 32'(cur_rdy), 32'(v.exp_lat == 1));
    lat = 1;
    while (!cur_wbv && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({v.name, "/lat"}, 32'(lat), 32'(v.exp_lat));
    chk({v.name, "/data"}, 32'(cur_data), 32'(v.exp_data));
    chk({v.name, "/err"}, 32'(cur_err), 32'(v.exp_err));
    $display("[TB] op %-12s data=%h err=%b lat=%0d", v.name, cur_data, cur_err, lat);
  endtask

  vec_t vecs[$];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cyc;

    //          name          alu       imm       pc        sdata    src rd  wr  sz  sx  ws    exp      err lat
    vecs.push_back(mk("alu",     16'h1234, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 2'd1, 16'h1234, 0, 1));
    vecs.push_back(mk("imm",     16'h0000, 16'hA5A5, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 2'd3, 16'hA5A5, 0, 1));
    vecs.push_back(mk("pc",      16'h0000, 16'h0000, 16'h0042, 16'h0000, 0, 0, 0, 0, 0, 2'd0, 16'h0042, 0, 1));
    vecs.push_back(mk("st_word", 16'h0010, 16'h0000, 16'h0000, 16'hBEEF, 1, 0, 1, 1, 0, 2'd1, 16'h0010, 0, 2));
    vecs.push_back(mk("ld_word", 16'h0010, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 1, 0, 2'd2, 16'hBEEF, 0, 2));
    vecs.push_back(mk("ld_b_sx", 16'h0011, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 0, 1, 2'd2, 16'hFFBE, 0, 2));
    vecs.push_back(mk("ld_b_zx", 16'h0011, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 0, 0, 2'd2, 16'h00BE, 0, 2));
    vecs.push_back(mk("ld_b_lo", 16'h0010, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 0, 1, 2'd2, 16'hFFEF, 0, 2));
    vecs.push_back(mk("st_misal",16'h0011, 16'h0000, 16'h0000, 16'h1111, 1, 0, 1, 1, 0, 2'd2, 16'h0000, 1, 2));
    vecs.push_back(mk("ld_after",16'h0010, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 1, 0, 2'd2, 16'hBEEF, 0, 2));
    vecs.push_back(mk("st_b_imm",16'h0111, 16'h127C, 16'h0000, 16'hFFFF, 0, 0, 1, 0, 0, 2'd3, 16'h127C, 0, 2));
    vecs.push_back(mk("ld_mix",  16'h0010, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 1, 0, 2'd2, 16'h7CEF, 0, 2));
    vecs.push_back(mk("ld_b_pos",16'h0011, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 0, 1, 2'd2, 16'h007C, 0, 2));
    vecs.push_back(mk("rd_wr",   16'h0010, 16'h0000, 16'h0000, 16'h0000, 1, 1, 1, 1, 0, 2'd2, 16'h0000, 1, 2));
    vecs.push_back(mk("ld_wrap", 16'h0210, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 1, 0, 2'd2, 16'h7CEF, 0, 2));
    vecs.push_back(mk("wb2_nomem",16'h0010,16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 2'd2, 16'h0000, 0, 1));
    vecs.push_back(mk("ld_misal",16'h0013, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 1, 0, 2'd1, 16'h0013, 1, 2));

    rst_n_a = 1'b0; rst_n_b = 1'b0; rst_n_c = 1'b0;
    in_valid_a = 1'b0; in_valid_b = 1'b0; in_valid_c = 1'b0;
    alu_result = '0; imm = '0; pc = '0; store_data = '0;
    data_in_src = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; size = 1'b0; sign_ext = 1'b0;
    wb_sel = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    rst_n_a = 1'b1; rst_n_b = 1'b1; rst_n_c = 1'b1;

    chk("rst/ready_a", 32'(in_ready_a), 32'd1);
    chk("rst/wbv_a", 32'(wb_valid_a), 32'd0);
    chk("rst/data_a", 32'(wb_data_a), 32'd0);
    chk("rst/err_a", 32'(err_a), 32'd0);
    chk("rst/ready_b", 32'(in_ready_b), 32'd1);
    chk("rst/wbv_b", 32'(wb_valid_b), 32'd0);
    $display("[TB] reset released");

    // Two ALU ops on consecutive edges: one writeback per cycle.
    sel = 0;
    alu_result = 16'h0001; wb_sel = 2'd1;
    in_valid_a = 1'b1;
    @(posedge clk); #1;
    chk("b2b/wbv1", 32'(wb_valid_a), 32'd1);
    chk("b2b/data1", 32'(wb_data_a), 32'h0001);
    chk("b2b/ready", 32'(in_ready_a), 32'd1);
    alu_result = 16'h0002;
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    chk("b2b/wbv2", 32'(wb_valid_a), 32'd1);
    chk("b2b/data2", 32'(wb_data_a), 32'h0002);
    @(posedge clk); #1;
    chk("b2b/pulse", 32'(wb_valid_a), 32'd0);
    $display("[TB] back-to-back alu ops done");

    foreach (vecs[i]) run_op(vecs[i]);
    @(posedge clk); #1;
    chk("vec/pulse", 32'(wb_valid_a), 32'd0);

    // WAIT_STATES = 3: complete one store, then abort a second one with reset.
    sel = 1;
    run_op(mk("b_st", 16'h0110, 16'h0000, 16'h0000, 16'hCAFE, 1, 0, 1, 1, 0, 2'd1, 16'h0110, 0, 4));
    alu_result = 16'h0010; store_data = 16'h1234; data_in_src = 1'b1;
    mem_rd = 1'b0; mem_wr = 1'b1; size = 1'b1; wb_sel = 2'd1;
    in_valid_b = 1'b1;
    @(posedge clk); #1;
    in_valid_b = 1'b0;
    chk("abort/busy1", 32'(in_ready_b), 32'd0);
    @(posedge clk); #1;
    chk("abort/busy2", 32'(in_ready_b), 32'd0);
    rst_n_b = 1'b0;
    @(posedge clk); #1;
    rst_n_b = 1'b1;
    chk("abort/ready", 32'(in_ready_b), 32'd1);
    n = 0;
    repeat (6) begin
      if (wb_valid_b) n++;
      @(posedge clk); #1;
    end
    chk("abort/no_wbv", 32'(n), 32'd0);
    $display("[TB] reset abort done, wb pulses=%0d", n);
    run_op(mk("b_ld_old", 16'h0010, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 1, 0, 2'd2, 16'hCAFE, 0, 4));

    // WAIT_STATES = 2: three loads with in_valid held high.
    alu_result = 16'h0020; mem_rd = 1'b1; mem_wr = 1'b0; size = 1'b1; wb_sel = 2'd2;
    in_valid_c = 1'b1;
    n = 0;
    cyc = 0;
    while (n < 3 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
      if (wb_valid_c) n++;
    end
    in_valid_c = 1'b0;
    chk("perf/ops", 32'(n), 32'd3);
    chk("perf/cycles", 32'(cyc), 32'd9);
`ifdef MEM_STAGE_PERF_EN
    chk("perf/stalls", 32'(stall_c), 32'd6);
    @(posedge clk); #1;
    chk("perf/hold", 32'(stall_c), 32'd6);
`endif
    $display("[TB] three loads done: ops=%0d cycles=%0d", n, cyc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_stage_ws.md
Name: mem_stage_ws

Overview:
- Parametrised successor to the pipeline MEM stage.
- Holds a byte-addressed little-endian data memory with a configurable wait-state count.
- Supports byte/word access with sign or zero extension, detects misaligned and illegal accesses, and stalls the upstream EX/MEM register through a valid/ready handshake.
- Selects the writeback value (PC, ALU, memory, immediate) for the WB stage.

Parameters:
DATA_W, 16, datapath/word width in bits; power of two, at least 16
DEPTH, 256, memory size in bytes; power of two
WAIT_STATES, 1, extra cycles per memory access; 0 to 15

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  EX/MEM presents an operation
in_ready  out  1  stage can accept an operation this cycle
alu_result  in  DATA_W  effective address, or ALU writeback value
imm  in  DATA_W  immediate operand
pc  in  DATA_W  PC value for link writeback
store_data  in  DATA_W  register store operand
data_in_src  in  1  store source: 1 = store_data, 0 = imm
mem_rd  in  1  load
mem_wr  in  1  store
size  in  1  0 = byte, 1 = full word
sign_ext  in  1  byte load: 1 = sign-extend, 0 = zero-extend
wb_sel  in  2  0 = pc, 1 = alu_result, 2 = memory data, 3 = imm
wb_valid  out  1  wb_data valid, one-cycle pulse per operation
wb_data  out  DATA_W  writeback value
err  out  1  one-cycle pulse with wb_valid on an illegal access

Behaviour:
- Reset (rst_n = 0 at a rising clk edge):
  - FSM goes to IDLE.
  - wb_valid = 0, wb_data = 0, err = 0, in_ready = 1 after reset.
  - Memory contents are not cleared.
  - Reset while BUSY aborts the operation: no memory write, no wb_valid.
- Accept: in_valid && in_ready at a rising edge. All inputs are captured into internal registers at accept; inputs are don't-care afterwards.
- FSM states:
  - IDLE: in_ready = 1.
    - On accept of a non-memory op (mem_rd = mem_wr = 0): stay IDLE; wb_valid next cycle. Throughput is 1 op/cycle.
    - On accept of a memory op with WAIT_STATES = 0: same as a non-memory op.
    - Otherwise: go to BUSY and load the wait counter with WAIT_STATES - 1.
  - BUSY: in_ready = 0.
    - Counter decrements each cycle.
    - At counter = 0: perform the access, assert wb_valid on the next cycle, return to IDLE.
  - Latency from accept to wb_valid is WAIT_STATES + 1 cycles, so back-to-back memory ops sustain one op per WAIT_STATES + 1 cycles.
- Addressing:
  - Byte address is alu_result[log2(DEPTH)-1:0]; upper bits are ignored, so addresses wrap modulo DEPTH.
  - Word access uses DATA_W/8 consecutive bytes, little-endian.
- Illegal access (err = 1; no memory write; memory data treated as 0):
  - word access whose address is not a multiple of DATA_W/8;
  - mem_rd && mem_wr both set.
- Store:
  - Data is store_data or imm, per data_in_src.
  - Byte store writes data[7:0] only; word store writes all bytes.
  - The write commits on the completion edge.
- Load:
  - Byte load extends bit 7 (sign_ext = 1) or pads with zeros (sign_ext = 0).
  - Word load returns the full word.
- Writeback mux (registered): wb_data = pc / alu_result / memory data / imm per wb_sel.
  - For wb_sel = 2 on a non-load op, memory data = 0.
- A load in the cycle after a store to the same address returns the newly stored data.

Optional Feature:
- Macro: MEM_STAGE_PERF_EN
- Defined:
  - Adds output port stall_cycles (16 bits).
  - Counts cycles with in_valid = 1 && in_ready = 0.
  - Saturates at 16'hFFFF.
  - Cleared by reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Defaults (DATA_W = 16, WAIT_STATES = 1):
  - ALU op with alu_result = 16'h1234, wb_sel = 1 -> wb_valid and wb_data = 16'h1234 one cycle after accept; in_ready stays 1.
  - Word store of store_data = 16'hBEEF at address 16'h0010 -> in_ready low 1 cycle, wb_valid at cycle 2.
    - Then a word load from 16'h0010 with wb_sel = 2 -> wb_data = 16'hBEEF at cycle 2.
- Byte load from 16'h0011 (byte 16'hBE):
  - sign_ext = 1 -> 16'hFFBE;
  - sign_ext = 0 -> 16'h00BE.
- Misaligned word store to 16'h0011 -> err = 1 with wb_valid; a following word load from 16'h0010 still returns 16'hBEEF.
- WAIT_STATES = 3, store issued, then rst_n = 0 on the 2nd BUSY cycle -> no wb_valid; a subsequent load shows the old memory contents. Address 16'h0110 with DEPTH = 256 accesses byte 16'h10.
- MEM_STAGE_PERF_EN defined, WAIT_STATES = 2, three back-to-back loads with in_valid held high -> stall_cycles = 6.
